seg7_scan_ctrl: RTL and testbench
=================================

# seg7_scan_ctrl

Time-multiplexed scan controller for a multi-digit common-anode 7-segment display on the Vaman board. Digit values are written over a valid/ready port into a shadow register file, then committed tear-free at each frame boundary. The controller shares the single 7-bit segment bus across NUM_DIGITS digit enables with a fixed refresh slot and an anti-ghosting blank interval. It replaces per-digit free-running counters as the display back end for the counter/clock demos.

## Interface
- NUM_DIGITS, 4, digits scanned; legal 2..8
- REFRESH_DIV, 20000, clk cycles per digit slot; ≥ BLANK_CYCLES+2
- BLANK_CYCLES, 200, cycles at slot start with display dark; ≥ 1
- AW, $clog2(NUM_DIGITS), derived write-address width

- clk  in  1  system clock (Sys_Clk0)
- rst  in  1  synchronous, active-high reset
- wr_valid  in  1  write request
- wr_ready  out  1  write accepted when wr_valid && wr_ready
- wr_addr  in  AW  digit index; 0 = least significant
- wr_data  in  4  BCD value
- lz_en  in  1  leading-zero suppression enable, sampled per slot
- seg  out  7  {a,b,c,d,e,f,g}, active-low
- an  out  NUM_DIGITS  digit enables, active-low, at most one low
- frame_done  out  1  one-cycle pulse at commit

## Operation
- Glyphs (abcdefg, active-low): 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100, 10..15=1111111.
- Per-slot FSM: BLANK (prescaler < BLANK_CYCLES) → SHOW (remaining cycles) → BLANK of the next digit.
- BLANK: an = all ones, seg = 1111111.
- SHOW: an[idx] = 0 and seg = glyph(active[idx]), unless suppressed.
- Prescaler runs 0..REFRESH_DIV-1 and wraps. On wrap, idx increments. NUM_DIGITS-1 wraps to 0.
- Commit occurs on the wrap from idx NUM_DIGITS-1 to 0:
  - active ← shadow, all digits in one cycle;
  - frame_done = 1 for that cycle;
  - wr_ready = 0 for that cycle.
- Writes:
  - Handshake updates shadow[wr_addr] ← wr_data.
  - wr_addr ≥ NUM_DIGITS is accepted and dropped.
  - Multiple writes to one digit before a commit: the last one wins.
  - Writes are never visible before the next commit.
- Leading-zero suppression: with lz_en = 1, digit i > 0 is blanked (an stays high, seg = 1111111) when active[j] = 0 for all j ≥ i. Digit 0 is never suppressed.

## Timing
- Reset values:
  - an = all ones, seg = 1111111, frame_done = 0, wr_ready = 0;
  - shadow and active = 0, idx = 0, prescaler = 0, FSM = BLANK.
- wr_ready rises on the first cycle after rst deasserts.
- seg, an and frame_done are registered: pins reflect FSM/idx state with 1-cycle latency.
- Write during a commit cycle: wr_ready = 0, so no transfer occurs. The master holds its request and the write lands the next cycle, in the following frame.
- Write in the cycle just before commit: it is captured and committed in the same frame.
- Frame period: NUM_DIGITS × REFRESH_DIV cycles. frame_done fires every frame, including the first one after reset.
- rst mid-slot: the next cycle shows reset values on all outputs. Pending shadow writes are discarded.
- Arithmetic:
  - prescaler width is $clog2(REFRESH_DIV); compare uses ==REFRESH_DIV-1, never overflow;
  - idx width is AW, with an explicit compare to NUM_DIGITS-1 for non-power-of-2 counts.

## Structure
- Package seg7_pkg holds:
  - SEG_BLANK = 7'b1111111;
  - glyph constants GLYPH_0..GLYPH_9;
  - the scan-state enum {ST_BLANK, ST_SHOW}.
- Sub-module seg7_decode: combinational 4-bit → 7-bit glyph lookup with default blank. It is instantiated once on the muxed active[idx].
- Top level holds the prescaler, idx, FSM, shadow/active arrays, suppression logic and output registers.

## Test plan
Bench parameters: NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2.

1. Reset released, no writes → wr_ready = 1 from cycle 1; per slot, an = 1111 for 2 cycles then 1110/1101/1011/0111; seg = 0000001; frame_done every 32 cycles.
2. Write digits 3,2,1,0 = 1,2,3,4 mid-frame → no change until frame_done. Next frame shows digit0 = 1001100 ("4") and digit3 = 1001111 ("1").
3. Drive wr_valid on the commit cycle → wr_ready = 0 that cycle. The write completes the next cycle and appears only after the following frame_done.
4. lz_en = 1 with active = {0,0,7,0} (digit3..0) → digits 3 and 2 are dark (an stays 1111 in their slots). Digit1 shows 0001111. Digit0 shows 0000001.
5. Write wr_data = 12 to digit 1 → after commit, seg = 1111111 with an = 1101 in SHOW. Write wr_addr = 3 in a NUM_DIGITS=3 build → dropped, display unchanged.
6. Assert rst during a SHOW of digit 2 with shadow writes pending → next cycle an = 1111, seg = 1111111. After release, all digits show "0" and the pending writes are gone.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan controller: active-low glyphs
// (bit order {a,b,c,d,e,f,g}) and the per-slot scan state.
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [6:0] GLYPH_0 = 7'b0000001;
  localparam logic [6:0] GLYPH_1 = 7'b1001111;
  localparam logic [6:0] GLYPH_2 = 7'b0010010;
  localparam logic [6:0] GLYPH_3 = 7'b0000110;
  localparam logic [6:0] GLYPH_4 = 7'b1001100;
  localparam logic [6:0] GLYPH_5 = 7'b0100100;
  localparam logic [6:0] GLYPH_6 = 7'b0100000;
  localparam logic [6:0] GLYPH_7 = 7'b0001111;
  localparam logic [6:0] GLYPH_8 = 7'b0000000;
  localparam logic [6:0] GLYPH_9 = 7'b0000100;

  typedef enum logic {
    ST_BLANK,
    ST_SHOW
  } scan_state_e;

endpackage

// File: rtl/seg7_decode.sv
// BCD to active-low 7-segment glyph; codes 10..15 render dark.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] glyph
);

  always_comb begin
    glyph = SEG_BLANK;
    case (bcd)
      4'd0:    glyph = GLYPH_0;
      4'd1:    glyph = GLYPH_1;
      4'd2:    glyph = GLYPH_2;
      4'd3:    glyph = GLYPH_3;
      4'd4:    glyph = GLYPH_4;
      4'd5:    glyph = GLYPH_5;
      4'd6:    glyph = GLYPH_6;
      4'd7:    glyph = GLYPH_7;
      4'd8:    glyph = GLYPH_8;
      4'd9:    glyph = GLYPH_9;
      default: glyph = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed common-anode display scanner with a shadow digit file that is
// committed to the displayed set once per frame, so frames never tear.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 20000,
  parameter int BLANK_CYCLES = 200,
  parameter int AW           = $clog2(NUM_DIGITS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [AW-1:0]         wr_addr,
  input  logic [3:0]            wr_data,
  input  logic                  lz_en,
  output logic [6:0]            seg,
  output logic [NUM_DIGITS-1:0] an,
  output logic                  frame_done
);

  localparam int PW = $clog2(REFRESH_DIV);
  localparam logic [PW-1:0] PRE_LAST  = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] PRE_BLANK = PW'(BLANK_CYCLES);
  localparam logic [AW-1:0] IDX_LAST  = AW'(NUM_DIGITS - 1);

  logic [PW-1:0]         pre;
  logic [PW-1:0]         pre_next;
  logic [AW-1:0]         idx;
  scan_state_e           state;
  logic                  lz_slot;
  logic [3:0]            shadow [NUM_DIGITS];
  logic [3:0]            active [NUM_DIGITS];
  logic                  slot_end;
  logic                  frame_end;
  logic                  wr_fire;
  logic                  addr_ok;
  logic [NUM_DIGITS-1:0] suppress;
  logic [3:0]            cur_digit;
  logic [6:0]            glyph;

  assign slot_end  = (pre == PRE_LAST);
  assign frame_end = slot_end && (idx == IDX_LAST);
  assign pre_next  = slot_end ? '0 : pre + 1'b1;
  assign wr_fire   = wr_valid && wr_ready;
  assign cur_digit = active[idx];

  // Out-of-range addresses only exist when NUM_DIGITS is not a power of two.
  generate
    if ((2 ** AW) > NUM_DIGITS) begin : g_addr_chk
      assign addr_ok = (wr_addr <= IDX_LAST);
    end else begin : g_addr_all
      assign addr_ok = 1'b1;
    end
  endgenerate

  // A digit is suppressed when it and every more significant digit are zero.
  always_comb begin
    logic upper_zero;
    suppress   = '0;
    upper_zero = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      upper_zero  = upper_zero && (active[i] == 4'd0);
      suppress[i] = lz_slot && upper_zero;
    end
  end

  seg7_decode u_decode (
    .bcd   (cur_digit),
    .glyph (glyph)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      pre        <= '0;
      idx        <= '0;
      state      <= ST_BLANK;
      lz_slot    <= 1'b0;
      wr_ready   <= 1'b0;
      frame_done <= 1'b0;
      an         <= '1;
      seg        <= SEG_BLANK;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        shadow[i] <= 4'd0;
        active[i] <= 4'd0;
      end
    end else begin
      pre <= pre_next;
      if (slot_end) begin
        idx     <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        lz_slot <= lz_en;
      end
      state <= (pre_next < PRE_BLANK) ? ST_BLANK : ST_SHOW;

      // The commit cycle is the one where frame_done is high; the write port
      // is closed then so the shadow copy is stable while it is transferred.
      frame_done <= frame_end;
      wr_ready   <= !frame_end;
      if (frame_done) begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
          active[i] <= shadow[i];
        end
      end
      if (wr_fire && addr_ok) begin
        shadow[wr_addr] <= wr_data;
      end

      if (state == ST_SHOW && !suppress[idx]) begin
        an  <= ~(NUM_DIGITS'(1) << idx);
        seg <= glyph;
      end else begin
        an  <= '1;
        seg <= SEG_BLANK;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench: stimulus pushes the expected look of each frame, a monitor
// captures every frame after frame_done and compares slot by slot.
module tb_seg7_scan_ctrl;

  localparam int BLK = 2;

  localparam logic [6:0] G0 = 7'b0000001;
  localparam logic [6:0] G1 = 7'b1001111;
  localparam logic [6:0] G2 = 7'b0010010;
  localparam logic [6:0] G3 = 7'b0000110;
  localparam logic [6:0] G4 = 7'b1001100;
  localparam logic [6:0] G7 = 7'b0001111;
  localparam logic [6:0] G8 = 7'b0000000;
  localparam logic [6:0] G9 = 7'b0000100;
  localparam logic [6:0] GB = 7'b1111111;
  localparam logic [3:0] A0 = 4'b1110;
  localparam logic [3:0] A1 = 4'b1101;
  localparam logic [3:0] A2 = 4'b1011;
  localparam logic [3:0] A3 = 4'b0111;
  localparam logic [3:0] AD = 4'b1111;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic [1:0] wr_addr = '0;
  logic [3:0] wr_data = '0;
  logic       lz_en = 1'b0;
  logic [6:0] seg;
  logic [3:0] an;
  logic       frame_done;

  logic       wr_valid2 = 1'b0;
  logic       wr_ready2;
  logic [1:0] wr_addr2 = '0;
  logic [3:0] wr_data2 = '0;
  logic [6:0] seg2;
  logic [2:0] an2;
  logic       frame_done2;

  int n_checks = 0;
  int n_pass = 0;
  int nf = 0;

  typedef struct {
    int         id;
    logic [3:0] an_e  [4];
    logic [6:0] seg_e [4];
  } frame_exp_t;

  frame_exp_t exp_q [$];

  seg7_scan_ctrl #(.NUM_DIGITS(4), .REFRESH_DIV(8), .BLANK_CYCLES(BLK)) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .lz_en      (lz_en),
    .seg        (seg),
    .an         (an),
    .frame_done (frame_done)
  );

  seg7_scan_ctrl #(.NUM_DIGITS(3), .REFRESH_DIV(8), .BLANK_CYCLES(BLK)) dut3 (
    .clk        (clk),
    .rst        (rst),
    .wr_valid   (wr_valid2),
    .wr_ready   (wr_ready2),
    .wr_addr    (wr_addr2),
    .wr_data    (wr_data2),
    .lz_en      (1'b0),
    .seg        (seg2),
    .an         (an2),
    .frame_done (frame_done2)
  );

  always #5 clk = ~clk;

  // Frame id = number of earlier frame_done pulses, read at the pulse's negedge.
  always @(posedge clk) if (frame_done) nf <= nf + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", name, act, req);
  endtask

  task automatic push_exp(input logic [3:0] a0, input logic [3:0] a1, input logic [3:0] a2,
                          input logic [3:0] a3, input logic [6:0] s0, input logic [6:0] s1,
                          input logic [6:0] s2, input logic [6:0] s3);
    frame_exp_t e;
    e.id = nf;
    e.an_e[0] = a0;  e.an_e[1] = a1;  e.an_e[2] = a2;  e.an_e[3] = a3;
    e.seg_e[0] = s0; e.seg_e[1] = s1; e.seg_e[2] = s2; e.seg_e[3] = s3;
    exp_q.push_back(e);
  endtask

  // Called at a negedge; returns at the negedge after the transfer edge.
  task automatic do_write(input bit second, input int addr, input int data, output int waits);
    waits = 0;
    if (!second) begin
      wr_valid = 1'b1; wr_addr = 2'(addr); wr_data = 4'(data);
      while (wr_ready !== 1'b1 && waits < 50) begin @(negedge clk); waits++; end
      if (wr_ready !== 1'b1) begin n_checks++; $display("FAIL write handshake: wr_ready stuck low"); end
      @(negedge clk);
      wr_valid = 1'b0;
    end else begin
      wr_valid2 = 1'b1; wr_addr2 = 2'(addr); wr_data2 = 4'(data);
      while (wr_ready2 !== 1'b1 && waits < 50) begin @(negedge clk); waits++; end
      if (wr_ready2 !== 1'b1) begin n_checks++; $display("FAIL write3 handshake: wr_ready stuck low"); end
      @(negedge clk);
      wr_valid2 = 1'b0;
    end
  endtask

  task automatic wait_next_fd(input string name);
    int t;
    t = 0;
    @(negedge clk);
    while (frame_done !== 1'b1 && t < 100) begin @(negedge clk); t++; end
    if (frame_done !== 1'b1) begin
      n_checks++;
      $display("FAIL %s: frame_done absent, got 0, required 1 within 100 cycles", name);
    end
  endtask

  task automatic capture_frame();
    logic [3:0] a_s [33];
    logic [6:0] s_s [33];
    logic       f_s [33];
    frame_exp_t e;
    int         id, k, bc;
    bit         aborted, fd_ok, ok;
    logic [3:0] ba, ea, bea;
    logic [6:0] bs, es, bes;
    id = nf;
    aborted = 0;
    for (int j = 1; j <= 32; j++) begin
      @(negedge clk);
      if (rst) begin aborted = 1; break; end
      a_s[j] = an; s_s[j] = seg; f_s[j] = frame_done;
    end
    if (aborted) return;
    fd_ok = f_s[32];
    for (int j = 1; j <= 31; j++) if (f_s[j]) fd_ok = 0;
    check("frame_done period 32", 32'(fd_ok), 32'd1);
    while (exp_q.size() > 0 && exp_q[0].id < id) begin
      e = exp_q.pop_front();
      n_checks++;
      $display("FAIL frame %0d: expectation not observed, got none, required one capture", e.id);
    end
    if (exp_q.size() > 0 && exp_q[0].id == id) begin
      e = exp_q.pop_front();
      for (int s = 0; s < 4; s++) begin
        ok = 1; bc = 0; ba = '0; bs = '0; bea = '0; bes = '0;
        for (int c = 0; c < 8; c++) begin
          k  = 1 + 8 * s + c;
          ea = (c < BLK) ? AD : e.an_e[s];
          es = (c < BLK) ? GB : e.seg_e[s];
          if (ok && (a_s[k] !== ea || s_s[k] !== es)) begin
            ok = 0; bc = c; ba = a_s[k]; bs = s_s[k]; bea = ea; bes = es;
          end
        end
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL frame %0d slot %0d cnt %0d: an=%b seg=%b, required an=%b seg=%b",
                      id, s, bc, ba, bs, bea, bes);
      end
    end
  endtask

  initial begin : monitor
    @(negedge clk);
    forever begin
      if (frame_done === 1'b1 && !rst) capture_frame();
      else @(negedge clk);
    end
  end

  initial begin : stim
    int w, t;
    repeat (3) @(negedge clk);
    check("reset an", 32'(an), 32'hF);
    check("reset seg", 32'(seg), 32'(GB));
    check("reset frame_done", 32'(frame_done), 32'd0);
    check("reset wr_ready", 32'(wr_ready), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("wr_ready after reset", 32'(wr_ready), 32'd1);

    wait_next_fd("frame 0");
    push_exp(A0, A1, A2, A3, G0, G0, G0, G0);
    @(negedge clk);
    do_write(0, 3, 1, w);
    do_write(0, 2, 2, w);
    do_write(0, 1, 3, w);
    do_write(0, 0, 4, w);

    wait_next_fd("frame 1");
    push_exp(A0, A1, A2, A3, G4, G3, G2, G1);
    check("wr_ready in commit cycle", 32'(wr_ready), 32'd0);
    do_write(0, 0, 9, w);
    check("commit-cycle write stall", 32'(w), 32'd1);

    wait_next_fd("frame 2");
    push_exp(A0, A1, A2, A3, G9, G3, G2, G1);
    repeat (31) @(negedge clk);
    do_write(0, 1, 7, w);
    check("frame_done after last-cycle write", 32'(frame_done), 32'd1);
    push_exp(A0, A1, A2, A3, G9, G7, G2, G1);
    lz_en = 1'b1;
    @(negedge clk);
    do_write(0, 3, 0, w);
    do_write(0, 2, 0, w);
    do_write(0, 0, 0, w);

    wait_next_fd("frame 4");
    push_exp(A0, A1, AD, AD, G0, G7, GB, GB);
    @(negedge clk);
    do_write(0, 1, 12, w);

    wait_next_fd("frame 5");
    push_exp(A0, A1, AD, AD, G0, GB, GB, GB);

    wait_next_fd("frame 6");
    lz_en = 1'b0;
    @(negedge clk);
    do_write(0, 2, 5, w);
    do_write(0, 3, 5, w);
    t = 0;
    while (an !== A2 && t < 40) begin @(negedge clk); t++; end
    check("digit 2 shown before reset", 32'(an), 32'(A2));
    rst = 1'b1;
    @(negedge clk);
    check("mid-slot reset an", 32'(an), 32'hF);
    check("mid-slot reset seg", 32'(seg), 32'(GB));
    check("mid-slot reset frame_done", 32'(frame_done), 32'd0);
    check("mid-slot reset wr_ready", 32'(wr_ready), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    wait_next_fd("frame after reset");
    push_exp(A0, A1, A2, A3, G0, G0, G0, G0);
    t = 0;
    while (exp_q.size() != 0 && t < 60) begin @(negedge clk); t++; end
    check("expectation queue drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Three-digit build: address 3 must be dropped, address 2 must land.
  initial begin : three_digit
    int w2, t2;
    logic [2:0] ea2;
    @(negedge clk);
    while (rst === 1'b1) @(negedge clk);
    @(negedge clk);
    do_write(1, 3, 8, w2);
    do_write(1, 2, 8, w2);
    t2 = 0;
    while (frame_done2 !== 1'b1 && t2 < 60) begin @(negedge clk); t2++; end
    if (frame_done2 !== 1'b1) begin
      n_checks++;
      $display("FAIL n3 frame_done: got 0, required 1 within 60 cycles");
    end
    for (int s = 0; s < 3; s++) begin
      repeat ((s == 0) ? 5 : 8) @(negedge clk);
      ea2 = ~(3'b001 << s);
      check($sformatf("n3 slot %0d an/seg", s), 32'({an2, seg2}),
            32'({ea2, (s == 2) ? G8 : G0}));
    end
  end

endmodule
